// File: rtl/shift_capture.sv
// Serial-entry capture: each short press/release shifts data_i into a word,
// full words are published with a one-cycle pulse, long holds clear the register.
module shift_capture #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       c,
    input  logic                       sw_o,
    input  logic                       data_i,
    output logic [WIDTH-1:0]           shift_o,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic [WIDTH-1:0]           word_o,
    output logic                       word_valid,
    output logic                       clr_pulse,
    output logic                       held_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] PEND_P = 3'd1;
    localparam logic [2:0] HELD   = 3'd2;
    localparam logic [2:0] PEND_R = 3'd3;
    localparam logic [2:0] SKIP_R = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [HW-1:0]    hold_cnt, hold_nxt;
    logic [WIDTH-1:0] shift_nxt, word_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             wv_nxt, clr_nxt, held_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            shift_o    <= '0;
            bit_cnt    <= '0;
            word_o     <= '0;
            word_valid <= 1'b0;
            clr_pulse  <= 1'b0;
            held_o     <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            shift_o    <= shift_nxt;
            bit_cnt    <= cnt_nxt;
            word_o     <= word_nxt;
            word_valid <= wv_nxt;
            clr_pulse  <= clr_nxt;
            held_o     <= held_nxt;
        end
    end

    // Press/release tracking; the action fires only on PEND_R -> IDLE
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        shift_nxt = shift_o;
        cnt_nxt   = bit_cnt;
        word_nxt  = word_o;
        wv_nxt    = 1'b0;
        clr_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (c) begin
                    state_nxt = sw_o ? SKIP_R : PEND_P;
                end
            end
            PEND_P: begin
                if (!c) begin
                    if (sw_o) begin
                        state_nxt = HELD;
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HELD: begin
                if (hold_cnt < HW'(HOLD_CYC)) begin
                    hold_nxt = hold_cnt + HW'(1);
                end
                if (c && sw_o) begin
                    state_nxt = PEND_R;
                end
            end
            PEND_R: begin
                if (!c) begin
                    if (sw_o) begin
                        state_nxt = HELD;
                    end else begin
                        state_nxt = IDLE;
                        if (hold_cnt >= HW'(HOLD_CYC)) begin
                            shift_nxt = '0;
                            cnt_nxt   = '0;
                            clr_nxt   = 1'b1;
                        end else begin
                            shift_nxt = {shift_o[WIDTH-2:0], data_i};
                            if (bit_cnt == CW'(WIDTH - 1)) begin
                                word_nxt = {shift_o[WIDTH-2:0], data_i};
                                wv_nxt   = 1'b1;
                                cnt_nxt  = '0;
                            end else begin
                                cnt_nxt = bit_cnt + CW'(1);
                            end
                        end
                    end
                end
            end
            SKIP_R: begin
                if (!c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        held_nxt = (state_nxt == HELD) || (state_nxt == PEND_R);
    end

endmodule
